// File: rtl/bloke2_pkg.sv
// Shared types and helpers for the bloke2 digest sink.
package bloke2_pkg;

    // Collector states: accept bytes, discard an over-long tail, hold result.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        OVER    = 2'd1,
        DONE    = 2'd2
    } sink_state_t;

    // Digest length in bytes of the bloke2 core.
    localparam int DIGEST_BYTES = 32;

    // One bit of the byte-lane write mask: lane is written when it equals cnt.
    function automatic logic lane_mask_bit(input int unsigned cnt, input int unsigned lane);
        return (cnt == lane);
    endfunction

endpackage

// File: rtl/bloke2_digest_sink.sv
// Collects the bloke2 core's digest byte stream into a parallel register,
// compares it with a reference and holds the result for the consumer.
//
// Handshake: the result is offered with digest_valid and taken on any rising
// edge where digest_valid && digest_ready; digest_out, match and the error
// flags are stable while digest_valid is high and not yet taken. The input
// byte stream has no backpressure; bytes arriving while a result is held and
// not taken are dropped and flagged through the sticky overrun bit.
module bloke2_digest_sink
    import bloke2_pkg::*;
#(
    parameter int W = DIGEST_BYTES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic [7:0]     din,
    input  logic           din_valid,
    input  logic           din_end,
    input  logic [W*8-1:0] expect_in,
    output logic [W*8-1:0] digest_out,
    output logic           digest_valid,
    input  logic           digest_ready,
    output logic           match,
    output logic           err_short,
    output logic           err_long,
    output logic           overrun,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] FULL = CW'(W);

    sink_state_t     state;
    logic [CW-1:0]   cnt;

    logic [W*8-1:0]  wr_base;
    logic [W*8-1:0]  digest_nx;
    logic [CW-1:0]   wr_lane;
    logic            wr_en;
    logic            hit;

    assign dbg_state = state;

    // Next-digest: current register (or a fresh zero digest when a handshake
    // completes in DONE) with the incoming byte merged into its lane.
    always_comb begin
        wr_base = digest_out;
        wr_lane = cnt;
        wr_en   = 1'b0;
        case (state)
            COLLECT: wr_en = din_valid;
            DONE: begin
                if (digest_ready) begin
                    wr_base = '0;
                    wr_lane = '0;
                    wr_en   = din_valid;
                end
            end
            default: wr_en = 1'b0;
        endcase
        digest_nx = wr_base;
        for (int k = 0; k < W; k++) begin
            if (wr_en && lane_mask_bit(32'(wr_lane), unsigned'(k))) begin
                digest_nx[8*k +: 8] = din;
            end
        end
        hit = (digest_nx == expect_in);
    end

    // Frame state machine with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            cnt          <= '0;
            digest_out   <= '0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            state        <= COLLECT;
            cnt          <= '0;
            digest_out   <= '0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (din_valid) begin
                        digest_out <= digest_nx;
                        cnt        <= (cnt == FULL) ? cnt : cnt + CW'(1);
                        if (din_end) begin
                            state        <= DONE;
                            digest_valid <= 1'b1;
                            err_short    <= (cnt < LAST);
                            err_long     <= 1'b0;
                            match        <= hit && (cnt == LAST);
                        end else if (cnt == LAST) begin
                            state <= OVER;
                        end
                    end
                end
                OVER: begin
                    // Tail bytes beyond the digest length are discarded.
                    if (din_valid && din_end) begin
                        state        <= DONE;
                        digest_valid <= 1'b1;
                        err_short    <= 1'b0;
                        err_long     <= 1'b1;
                        match        <= 1'b0;
                    end
                end
                DONE: begin
                    if (digest_ready) begin
                        digest_out   <= digest_nx;
                        cnt          <= din_valid ? CW'(1) : '0;
                        digest_valid <= 1'b0;
                        match        <= 1'b0;
                        err_short    <= 1'b0;
                        err_long     <= 1'b0;
                        state        <= COLLECT;
                        // A one-byte frame ending on the handshake cycle is short.
                        if (din_valid && din_end) begin
                            state        <= DONE;
                            digest_valid <= 1'b1;
                            err_short    <= 1'b1;
                        end
                    end else if (din_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bloke2_digest_sink.sv
// Directed and randomized checks of bloke2_digest_sink against a byte-queue
// model of the digest framing rules.
module tb_bloke2_digest_sink;

    localparam int W = 32;
    localparam int DB = W * 8;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_end;
    logic [DB-1:0] expect_in;
    logic [DB-1:0] digest_out;
    logic          digest_valid;
    logic          digest_ready;
    logic          match;
    logic          err_short;
    logic          err_long;
    logic          overrun;
    logic [1:0]    dbg_state;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0]    fq[$];
    logic [7:0]    bq[$];
    logic [DB-1:0] exp_q[$];
    logic          exp_ovr = 1'b0;
    logic [DB-1:0] held;

    bloke2_digest_sink #(.W(W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .din(din), .din_valid(din_valid), .din_end(din_end),
        .expect_in(expect_in), .digest_out(digest_out),
        .digest_valid(digest_valid), .digest_ready(digest_ready),
        .match(match), .err_short(err_short), .err_long(err_long),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // Clock and reset-time defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model digest: first W bytes of the frame in arrival order, rest zero.
    function automatic logic [DB-1:0] pack_q(input logic [7:0] q[$]);
        logic [DB-1:0] d = '0;
        for (int k = 0; k < W && k < q.size(); k++) d[8*k +: 8] = q[k];
        return d;
    endfunction

    task automatic fill_random(input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drive fq as one frame; ready toggles randomly since it must be ignored
    // while no result is held. Returns just after the edge taking the last byte.
    task automatic send_fq();
        for (int i = 0; i < fq.size(); i++) begin
            @(posedge clk); #1;
            din          = fq[i];
            din_valid    = 1'b1;
            din_end      = (i == fq.size() - 1);
            digest_ready = 1'($urandom_range(0, 1));
        end
        exp_q.push_back(pack_q(fq));
        @(posedge clk); #1;
        din_valid    = 1'b0;
        din_end      = 1'b0;
        digest_ready = 1'b0;
    endtask

    task automatic check_result(input string tag);
        logic [DB-1:0] exp_d;
        logic          sh, lg, mt;
        int            n;
        n     = fq.size();
        exp_d = exp_q.pop_front();
        sh    = (n < W);
        lg    = (n > W);
        mt    = !sh && !lg && (exp_d == expect_in);
        chk({tag, "_valid"},  DB'(digest_valid), DB'(1'b1));
        chk({tag, "_digest"}, digest_out, exp_d);
        chk({tag, "_match"},  DB'(match), DB'(mt));
        chk({tag, "_short"},  DB'(err_short), DB'(sh));
        chk({tag, "_long"},   DB'(err_long), DB'(lg));
        chk({tag, "_ovr"},    DB'(overrun), DB'(exp_ovr));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"},  DB'(digest_valid), DB'(1'b0));
        chk({tag, "_digest"}, digest_out, '0);
        chk({tag, "_flags"},  DB'({match, err_short, err_long}), DB'(3'b000));
        chk({tag, "_ovr"},    DB'(overrun), DB'(exp_ovr));
        chk({tag, "_state"},  DB'(dbg_state), DB'(2'd0));
    endtask

    task automatic ack(input string tag);
        @(posedge clk); #1;
        digest_ready = 1'b1;
        @(posedge clk); #1;
        digest_ready = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; din_end = 1'b0;
        expect_in = '0; digest_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;

        // Correct frame with the 0x00..0x1F pattern
        fq.delete();
        for (int i = 0; i < W; i++) fq.push_back(8'(i));
        expect_in = pack_q(fq);
        send_fq();
        check_result("correct");
        chk("correct_lane0", DB'(digest_out[7:0]), DB'(8'h00));
        ack("correct_ack");

        // Short frame: 20 bytes
        fill_random(20);
        expect_in = pack_q(fq);
        send_fq();
        check_result("short");
        ack("short_ack");

        // Long frame: 35 bytes
        fill_random(35);
        expect_in = pack_q(fq);
        send_fq();
        check_result("long");
        ack("long_ack");

        // Back-to-back frames with ready held high
        fill_random(W);
        bq.delete();
        for (int i = 0; i < W; i++) bq.push_back(8'($urandom_range(0, 255)));
        expect_in    = pack_q(fq);
        digest_ready = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (i == W) begin
                chk("b2b_a_valid",  DB'(digest_valid), DB'(1'b1));
                chk("b2b_a_digest", digest_out, pack_q(fq));
                chk("b2b_a_match",  DB'(match), DB'(1'b1));
                expect_in = pack_q(bq);
            end
            if (i == W + 1) begin
                chk("b2b_gap_valid", DB'(digest_valid), DB'(1'b0));
                chk("b2b_b_lane0",   digest_out, DB'(bq[0]));
            end
            din       = (i < W) ? fq[i] : bq[i-W];
            din_valid = 1'b1;
            din_end   = (i == W - 1) || (i == 2 * W - 1);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_end   = 1'b0;
        chk("b2b_b_valid",  DB'(digest_valid), DB'(1'b1));
        chk("b2b_b_digest", digest_out, pack_q(bq));
        chk("b2b_b_match",  DB'(match), DB'(1'b1));
        @(posedge clk); #1;
        digest_ready = 1'b0;
        check_idle("b2b_end");

        // Overrun: bytes arrive while the result is held
        fill_random(W);
        expect_in = pack_q(fq);
        held      = pack_q(fq);
        send_fq();
        check_result("ovr_frame");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            din       = 8'($urandom_range(0, 255));
            din_valid = 1'b1;
            din_end   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_end   = 1'b0;
        exp_ovr   = 1'b1;
        chk("ovr_flag",   DB'(overrun), DB'(exp_ovr));
        chk("ovr_valid",  DB'(digest_valid), DB'(1'b1));
        chk("ovr_digest", digest_out, held);
        clear = 1'b1;
        @(posedge clk); #1;
        clear   = 1'b0;
        exp_ovr = 1'b0;
        check_idle("clear");

        // Mismatch in byte 17
        fill_random(W);
        expect_in = pack_q(fq);
        expect_in[8*17 +: 8] = expect_in[8*17 +: 8] ^ 8'($urandom_range(1, 255));
        send_fq();
        check_result("mismatch");
        chk("mismatch_match0", DB'(match), DB'(1'b0));
        ack("mismatch_ack");

        // Asynchronous reset at byte 10 of the next frame
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            din       = 8'($urandom_range(1, 255));
            din_valid = 1'b1;
            din_end   = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        din_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized frames covering lengths around the digest boundary
        for (int f = 0; f < 8; f++) begin
            fill_random($urandom_range(1, W + 8));
            expect_in = pack_q(fq);
            if ($urandom_range(0, 3) == 0) expect_in[0] = ~expect_in[0];
            send_fq();
            check_result($sformatf("rand%0d", f));
            ack($sformatf("rand%0d_ack", f));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bloke2_digest_sink.md
# bloke2_digest_sink

Byte-stream digest collector placed directly downstream of the bloke2 hash core. It consumes the core's `dout`/`dout_valid`/`dout_end` byte stream and assembles the W-byte digest into a parallel register. It compares the digest against an expected value, flags framing errors, and then holds the result behind a valid/ready handshake for the host or test controller.

## Interface
Parameters:
- `W`, default 32: digest length in bytes. Matches the core's W, so the digest is W*8 bits. Legal range is W ≥ 2.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `clear`  in  1  — synchronous abort. Returns the block to COLLECT and zeroes all state. Has priority over every other input.
- `din`  in  8  — digest byte. Connects to core `dout`.
- `din_valid`  in  1  — byte strobe. Connects to core `dout_valid`. There is no backpressure: the core cannot stall.
- `din_end`  in  1  — marks the last byte of the stream. Qualified by `din_valid`.
- `expect_in`  in  W*8  — reference digest. Sampled only on the COLLECT/OVER→DONE transition.
- `digest_out`  out  W*8  — assembled digest. Byte k occupies bits [8k+7:8k], and byte 0 is the first byte received.
- `digest_valid`  out  1  — result held.
- `digest_ready`  in  1  — consumer accepts the result.
- `match`  out  1  — digest equals `expect_in` and no framing error occurred.
- `err_short`  out  1  — `din_end` arrived before byte W-1.
- `err_long`  out  1  — more than W bytes arrived before `din_end`.
- `overrun`  out  1  — sticky. Set when a byte is dropped in DONE. Cleared only by `rst` or `clear`.

## Operation
- State machine has three states:
  - COLLECT: accept bytes.
  - OVER: discard bytes until `din_end`.
  - DONE: hold the result.
- Byte counter `cnt` is ceil(log2(W))+1 bits wide and saturates at W.
- In COLLECT, on `din_valid`:
  - The byte is written to lane `cnt`, then `cnt` is incremented.
  - If `din_end` is set and `cnt` = W-1: go to DONE with a correct frame.
  - If `din_end` is set and `cnt` < W-1: go to DONE with `err_short` = 1 and `match` = 0. Unwritten lanes stay 0.
  - If `din_end` is clear and `cnt` = W-1: go to OVER.
- In OVER, bytes are discarded and not written. On `din_valid && din_end`: go to DONE with `err_long` = 1 and `match` = 0.
- On entry to DONE, `match` is registered as (next-digest == `expect_in`) && !`err_short` && !`err_long`. The next-digest value includes the final byte.
- In DONE:
  - `digest_out`, `match` and the error flags are held stable until the handshake.
  - On `digest_ready`: go to COLLECT. `cnt`, the digest register, `match`, `err_short` and `err_long` are all cleared.
  - `digest_ready` and `din_valid` in the same cycle: the handshake completes and the byte is written as lane 0 of the next digest, with `cnt` = 1. If `din_end` is also set, the block goes to DONE again with `err_short`.
  - `din_valid` without `digest_ready`: the byte is dropped and `overrun` is set.
- `clear` during any state aborts the frame. `overrun` is also cleared.

## Timing
- Reset values: all outputs are 0, the state is COLLECT, and `cnt` = 0.
- Latency: `digest_valid`, `match` and the error flags become visible on the edge that accepts the final byte. They are registered outputs and are observable in the following cycle.
- `digest_valid` remains high until the cycle after `digest_ready` is sampled high.
- A `digest_ready` pulse while `digest_valid` = 0 is ignored.
- Asynchronous reset mid-frame discards the partial digest immediately. There is no recovery of the partial frame.
- Throughput: one byte per cycle, with no bubbles required between frames if `digest_ready` is held high.

## Structure
- `bloke2_pkg` holds:
  - the state enum `sink_state_t` (COLLECT, OVER, DONE);
  - the `DIGEST_BYTES` constant;
  - the byte-lane helper function computing the lane-write mask from `cnt`.
- Single module with no sub-module. The comparator is a W*8-bit equality on the next-state digest, kept inline.

## Test plan
- Correct frame: W=32 bytes 0x00..0x1F with `din_end` on byte 31, and `expect_in` equal to that pattern → `digest_valid` = 1 one cycle later, `match` = 1, no errors, `digest_out`[7:0] = 0x00.
- Short frame: 20 bytes with `din_end` on byte 19 → `err_short` = 1, `match` = 0, lanes 20..31 = 0.
- Long frame: 35 bytes with `din_end` on byte 34 → `err_long` = 1, `match` = 0, `digest_out` holds bytes 0..31 only.
- Back-to-back frames: `digest_ready` tied high, two 32-byte frames with no gap → two `digest_valid` pulses, and the first byte of frame 2 lands in lane 0.
- Overrun: `digest_ready` held low in DONE while 3 bytes arrive → `overrun` = 1, `digest_out` unchanged. Then `clear` → all outputs return to 0.
- Mismatch and reset: `expect_in` differs in byte 17 → `match` = 0. Asserting `rst` low at byte 10 of the next frame → all outputs are 0 immediately.
